phy_tx_sequencer: RTL and testbench
===================================

Name: phy_tx_sequencer

Overview:
- Transmit-side scheduler for the 8b10b PHY.
- Tracks pending link-control events: ACKs, and credit grants for VC0 and VC1. Arbitrates them against data packets waiting in the upstream buffer.
- Sequences the encoder one frame at a time: start pulse, frame-type select, data fetch enable.
- Sits between the link-layer event sources and the encoder/comma generator.

Parameters:
- COUNTER_SIZE, 4, width of each pending-event counter; saturates at 2^COUNTER_SIZE-1.
- MAX_CTRL_RUN, 4, number of consecutive control frames allowed while data_req is high before a data frame is forced.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- ack_req  input  1  one-cycle pulse; one ACK becomes pending
- grtcred0_req  input  1  one-cycle pulse; one VC0 credit grant becomes pending
- grtcred1_req  input  1  one-cycle pulse; one VC1 credit grant becomes pending
- data_req  input  1  level; a complete packet is available upstream
- enc_ready  input  1  level; encoder idle and able to accept a frame start
- done  input  1  pulse; encoder finished the current control frame
- packet_done  input  1  pulse; last word of the current data packet transmitted
- start  output  1  one-cycle pulse; encoder begins the frame given by comma_sel
- comma_sel  output  3  frame type: 0 NONE, 1 ACK, 2 GRTCRED0, 3 GRTCRED1, 4 DATA
- get_data  output  1  high for the whole data frame; upstream buffer supplies words
- ack_full  output  1  ACK counter at maximum
- grtcred0_full  output  1  VC0 grant counter at maximum
- grtcred1_full  output  1  VC1 grant counter at maximum
- overflow_err  output  1  sticky; set when a request arrives while its counter is full
- busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low. While reset is asserted:
  - all counters are 0; FSM is in IDLE;
  - start, get_data, busy, overflow_err and all *_full outputs are 0; comma_sel is 0;
  - the control-run counter and the VC round-robin pointer (initial value VC0) are cleared.
- Counters (ACK, G0, G1):
  - A request increments its counter by 1. A grant of that frame type decrements it by 1.
  - Request and grant in the same cycle leave the counter unchanged.
  - A request at maximum (with no same-cycle grant) is dropped, the counter holds, and overflow_err is set.
  - No wrap-around. A counter never decrements below 0.
  - *_full is high exactly when its counter equals all-ones; it is registered with the counter.
- FSM states: IDLE, CTRL, DATA. Outputs are registered.
- IDLE with enc_ready=1, selection in this order:
  1. data forced: data_req=1 and the control-run counter equals MAX_CTRL_RUN;
  2. ACK counter nonzero;
  3. credit grants: G0/G1 by round-robin when both are nonzero; the pointer flips to the other VC after each grant frame; if only one is nonzero, that one is taken;
  4. data_req=1.
- On selection:
  - start=1 for exactly one cycle, and comma_sel is loaded with the chosen type;
  - the chosen counter decrements in the same cycle;
  - the FSM goes to CTRL (types 1-3) or DATA (type 4).
- Control-run counter: increments on each control frame started while data_req=1 and saturates at MAX_CTRL_RUN. It clears when a data frame is started or when data_req=0 at selection.
- IDLE with enc_ready=0, or with nothing pending: stay in IDLE; start=0.
- CTRL: comma_sel held. On done, go to IDLE and set comma_sel to 0 on the next cycle. packet_done is ignored.
- DATA: get_data=1 and comma_sel=4 held. On packet_done, get_data deasserts and the FSM returns to IDLE. data_req falling mid-packet is ignored, and done is ignored.
- Latency: a request sampled at edge k makes the counter nonzero after k. With the FSM in IDLE and enc_ready=1, start is high in the cycle following edge k+1.
- Back-to-back frames: the earliest new start is the cycle after the IDLE return, so there is at least one idle cycle between frames.
- done or packet_done arriving in IDLE is ignored.
- Asserting nRST mid-frame aborts immediately: all outputs go to reset values and all pending counts are lost.

Test Plan:
- Reset then a single ack_req, with enc_ready=1 -> start pulses 2 cycles later with comma_sel=1; ACK counter returns to 0; after done, busy=0 and comma_sel=0.
- 16 ack_req pulses with enc_ready=0, COUNTER_SIZE=4 -> counter reaches 15 and ack_full=1 after the 15th; the 16th request sets overflow_err=1; overflow_err stays 1 after counts drain.
- 2 grtcred0_req and 2 grtcred1_req pending, done returned each frame -> frame order GRTCRED0, GRTCRED1, GRTCRED0, GRTCRED1.
- data_req=1 held and ACK counter preloaded to 10 -> 4 ACK frames, then a DATA frame (get_data=1 until packet_done), then ACK frames resume.
- Same-cycle ack_req and ACK grant with counter=1 -> counter stays 1 and a second ACK frame follows.
- nRST pulsed low mid-DATA frame -> get_data=0, start=0, busy=0 and counters 0 immediately; packet_done arriving afterwards produces no activity.

Source files
------------

// File: rtl/phy_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_sequencer_if
// Purpose  : Encoder-side handshake between the TX sequencer and the 8b10b
//            encoder / comma generator.
// Revision : 1.0 - initial release
// ============================================================================
interface phy_tx_sequencer_if;
  logic       start;        // one-cycle frame start pulse
  logic [2:0] comma_sel;    // frame type for the current frame
  logic       get_data;     // upstream buffer supplies words while high
  logic       enc_ready;    // encoder idle, can accept a start
  logic       done;         // control frame finished
  logic       packet_done;  // last word of data packet sent

  // Sequencer side
  modport master (
    output start,
    output comma_sel,
    output get_data,
    input  enc_ready,
    input  done,
    input  packet_done
  );

  // Encoder side
  modport slave (
    input  start,
    input  comma_sel,
    input  get_data,
    output enc_ready,
    output done,
    output packet_done
  );
endinterface
`default_nettype wire

// File: rtl/phy_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_sequencer
// Purpose  : Transmit-side scheduler for the 8b10b PHY. Counts pending ACK and
//            VC0/VC1 credit-grant events, arbitrates them against upstream
//            data packets and sequences the encoder one frame at a time.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx_sequencer #(
  parameter int COUNTER_SIZE = 4,  // width of each pending-event counter
  parameter int MAX_CTRL_RUN = 4   // control frames allowed before data is forced (>= 1)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ack_req,
  input  logic                grtcred0_req,
  input  logic                grtcred1_req,
  input  logic                data_req,
  phy_tx_sequencer_if.master  enc,
  output logic                ack_full,
  output logic                grtcred0_full,
  output logic                grtcred1_full,
  output logic                overflow_err,
  output logic                busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                    c_run_w   = $clog2(MAX_CTRL_RUN + 1);
  localparam logic [c_run_w-1:0]    c_run_max = c_run_w'(MAX_CTRL_RUN);
  localparam logic [COUNTER_SIZE-1:0] c_cnt_max = '1;

  // Frame-type encoding on comma_sel
  localparam logic [2:0] c_sel_none = 3'd0;
  localparam logic [2:0] c_sel_ack  = 3'd1;
  localparam logic [2:0] c_sel_g0   = 3'd2;
  localparam logic [2:0] c_sel_g1   = 3'd3;
  localparam logic [2:0] c_sel_data = 3'd4;

  // Event index inside the per-event vectors
  localparam int c_ev_ack = 0;
  localparam int c_ev_g0  = 1;
  localparam int c_ev_g1  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic                 r_start;
  logic [2:0]           r_comma_sel;
  logic                 r_get_data;
  logic                 r_busy;
  logic                 r_overflow;
  logic [c_run_w-1:0]   r_run_cnt;
  logic                 r_rr_vc1;     // 1: VC1 wins the next tie, 0: VC0 wins

  logic [2:0]           w_req;        // request pulses, one bit per event type
  logic [2:0]           w_grant;      // counter consumed by a frame start this cycle
  logic [2:0]           w_cnt_nz;     // counter holds at least one pending event
  logic [2:0]           w_full;       // registered all-ones flags
  logic [2:0]           w_ovf_hit;    // request dropped because counter is full
  logic [2:0]           w_sel;        // frame type the arbiter would pick now
  logic                 w_take;       // a frame starts at the next edge

  assign w_req = {grtcred1_req, grtcred0_req, ack_req};

  // --------------------------------------------------------------------------
  // Pending-event counters: saturating, request and grant in one cycle cancel
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [COUNTER_SIZE-1:0] r_cnt;
      logic                    r_full;
      logic [COUNTER_SIZE-1:0] w_cnt_nxt;

      // Next count: +1 on a lone request (unless full), -1 on a lone grant
      always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_req[gi] && !w_grant[gi]) begin
          if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + COUNTER_SIZE'(1);
          end
        end else if (!w_req[gi] && w_grant[gi]) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - COUNTER_SIZE'(1);
          end
        end
      end

      // Counter and its full flag are registered together so they never skew
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_cnt  <= '0;
          r_full <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_full <= (w_cnt_nxt == c_cnt_max);
        end
      end

      assign w_cnt_nz[gi]  = (r_cnt != '0);
      assign w_full[gi]    = r_full;
      assign w_ovf_hit[gi] = w_req[gi] && !w_grant[gi] && (r_cnt == c_cnt_max);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame arbitration
  // --------------------------------------------------------------------------
  // Priority: forced data after a long control run, ACK, credit grants
  // (round-robin on a tie), then ordinary data.
  always_comb begin
    w_sel = c_sel_none;
    if (data_req && (r_run_cnt == c_run_max)) begin
      w_sel = c_sel_data;
    end else if (w_cnt_nz[c_ev_ack]) begin
      w_sel = c_sel_ack;
    end else if (w_cnt_nz[c_ev_g0] && w_cnt_nz[c_ev_g1]) begin
      w_sel = r_rr_vc1 ? c_sel_g1 : c_sel_g0;
    end else if (w_cnt_nz[c_ev_g0]) begin
      w_sel = c_sel_g0;
    end else if (w_cnt_nz[c_ev_g1]) begin
      w_sel = c_sel_g1;
    end else if (data_req) begin
      w_sel = c_sel_data;
    end
  end

  assign w_take = (r_state == ST_IDLE) && enc.enc_ready && (w_sel != c_sel_none);

  assign w_grant[c_ev_ack] = w_take && (w_sel == c_sel_ack);
  assign w_grant[c_ev_g0]  = w_take && (w_sel == c_sel_g0);
  assign w_grant[c_ev_g1]  = w_take && (w_sel == c_sel_g1);

  // --------------------------------------------------------------------------
  // Frame sequencer FSM with registered encoder-side outputs
  // --------------------------------------------------------------------------
  // One frame at a time: IDLE picks and starts a frame, CTRL/DATA wait for the
  // matching completion pulse and ignore the other one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_start     <= 1'b0;
      r_comma_sel <= c_sel_none;
      r_get_data  <= 1'b0;
      r_busy      <= 1'b0;
      r_run_cnt   <= '0;
      r_rr_vc1    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_start     <= 1'b1;
            r_comma_sel <= w_sel;
            r_busy      <= 1'b1;
            if (w_sel == c_sel_data) begin
              r_state    <= ST_DATA;
              r_get_data <= 1'b1;
              r_run_cnt  <= '0;
            end else begin
              r_state <= ST_CTRL;
              // Only control frames that delay waiting data count toward the run
              if (data_req) begin
                if (r_run_cnt != c_run_max) begin
                  r_run_cnt <= r_run_cnt + c_run_w'(1);
                end
              end else begin
                r_run_cnt <= '0;
              end
            end
            // Next tie goes to the VC that was not just served
            if (w_sel == c_sel_g0) begin
              r_rr_vc1 <= 1'b1;
            end else if (w_sel == c_sel_g1) begin
              r_rr_vc1 <= 1'b0;
            end
          end
        end

        ST_CTRL: begin
          if (enc.done) begin
            r_state     <= ST_IDLE;
            r_comma_sel <= c_sel_none;
            r_busy      <= 1'b0;
          end
        end

        ST_DATA: begin
          if (enc.packet_done) begin
            r_state     <= ST_IDLE;
            r_comma_sel <= c_sel_none;
            r_get_data  <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_comma_sel <= c_sel_none;
          r_get_data  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: any request dropped by a full counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf_hit) begin
      r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign enc.start     = r_start;
  assign enc.comma_sel = r_comma_sel;
  assign enc.get_data  = r_get_data;

  assign ack_full      = w_full[c_ev_ack];
  assign grtcred0_full = w_full[c_ev_g0];
  assign grtcred1_full = w_full[c_ev_g1];
  assign overflow_err  = r_overflow;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_tx_sequencer
// Purpose  : Self-checking bench for phy_tx_sequencer. A pending-count model
//            predicts each frame type; a monitor compares every start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_sequencer;
  localparam int CS   = 4;
  localparam int MR   = 4;
  localparam int CMAX = (1 << CS) - 1;

  logic CLK          = 1'b0;
  logic nRST         = 1'b1;
  logic ack_req      = 1'b0;
  logic grtcred0_req = 1'b0;
  logic grtcred1_req = 1'b0;
  logic data_req     = 1'b0;
  logic ack_full, grtcred0_full, grtcred1_full, overflow_err, busy;

  phy_tx_sequencer_if enc_if ();

  phy_tx_sequencer #(.COUNTER_SIZE(CS), .MAX_CTRL_RUN(MR)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ack_req      (ack_req),
    .grtcred0_req (grtcred0_req),
    .grtcred1_req (grtcred1_req),
    .data_req     (data_req),
    .enc          (enc_if),
    .ack_full     (ack_full),
    .grtcred0_full(grtcred0_full),
    .grtcred1_full(grtcred1_full),
    .overflow_err (overflow_err),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // Reference model: pending counts per event (0 ACK, 1 VC0, 2 VC1)
  int m_cnt[3];
  bit m_ovf;
  bit m_next_vc1;
  int m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_ovf      = 1'b0;
    m_next_vc1 = 1'b0;
    m_run      = 0;
  endfunction

  function automatic void m_req(input int i);
    if (m_cnt[i] == CMAX) m_ovf = 1'b1;
    else m_cnt[i] = m_cnt[i] + 1;
  endfunction

  function automatic int m_select(input bit dreq);
    if (dreq && m_run == MR) return 4;
    if (m_cnt[0] > 0) return 1;
    if (m_cnt[1] > 0 && m_cnt[2] > 0) return m_next_vc1 ? 3 : 2;
    if (m_cnt[1] > 0) return 2;
    if (m_cnt[2] > 0) return 3;
    if (dreq) return 4;
    return 0;
  endfunction

  function automatic void m_grant(input int t, input bit dreq);
    if (t == 4) begin
      m_run = 0;
    end else begin
      m_cnt[t-1] = m_cnt[t-1] - 1;
      if (t == 2) m_next_vc1 = 1'b1;
      if (t == 3) m_next_vc1 = 1'b0;
      m_run = dreq ? ((m_run < MR) ? m_run + 1 : MR) : 0;
    end
  endfunction

  // Monitor: every start pulse must match the oldest predicted frame type
  always @(negedge CLK) begin
    if (enc_if.start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_start: comma_sel=%0d with no frame expected (t=%0t)", enc_if.comma_sel, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("start_comma_sel", 32'(enc_if.comma_sel), e);
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, ":ack_full"},      ack_full,      m_cnt[0] == CMAX);
    check({tag, ":grtcred0_full"}, grtcred0_full, m_cnt[1] == CMAX);
    check({tag, ":grtcred1_full"}, grtcred1_full, m_cnt[2] == CMAX);
    check({tag, ":overflow_err"},  overflow_err,  m_ovf);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    ack_req = 0; grtcred0_req = 0; grtcred1_req = 0;
    enc_if.enc_ready = 0; enc_if.done = 0; enc_if.packet_done = 0;
    #1;
    check("rst_start",     enc_if.start,     0);
    check("rst_get_data",  enc_if.get_data,  0);
    check("rst_comma_sel", enc_if.comma_sel, 0);
    check("rst_busy",      busy,             0);
    m_reset();
    check_status("rst");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.delete();
  endtask

  task automatic pulse_reqs(input bit a, input bit g0, input bit g1);
    ack_req = a; grtcred0_req = g0; grtcred1_req = g1;
    @(negedge CLK);
    ack_req = 0; grtcred0_req = 0; grtcred1_req = 0;
    if (a)  m_req(0);
    if (g0) m_req(1);
    if (g1) m_req(2);
  endtask

  // One arbitration round: predict, start, hold, complete, verify return to IDLE
  task automatic run_frame(input bit co_ack, input bit rnd);
    int t;
    int hold;
    bit a, g0, g1;
    t = m_select(data_req);
    if (t == 0) begin
      enc_if.enc_ready = 1;
      enc_if.done = 1;
      @(negedge CLK);
      enc_if.done = 0;
      enc_if.packet_done = 1;
      @(negedge CLK);
      enc_if.packet_done = 0;
      repeat (2) @(negedge CLK);
      enc_if.enc_ready = 0;
      check("idle_busy", busy, 0);
      check("idle_get_data", enc_if.get_data, 0);
      return;
    end
    exp_q.push_back(t);
    enc_if.enc_ready = 1;
    ack_req = co_ack;
    @(negedge CLK);
    enc_if.enc_ready = 0;
    ack_req = 0;
    m_grant(t, data_req);
    if (co_ack) begin
      if (t == 1) m_cnt[0] = m_cnt[0] + 1;
      else m_req(0);
    end
    check("frame_busy", busy, 1);
    check("frame_get_data", enc_if.get_data, t == 4);
    hold = rnd ? $urandom_range(1, 4) : 1;
    for (int i = 0; i < hold; i++) begin
      if (t == 4) enc_if.done = 1; else enc_if.packet_done = 1;
      a  = rnd && ($urandom_range(0, 3) == 0);
      g0 = rnd && ($urandom_range(0, 3) == 0);
      g1 = rnd && ($urandom_range(0, 3) == 0);
      ack_req = a; grtcred0_req = g0; grtcred1_req = g1;
      if (rnd && $urandom_range(0, 3) == 0) data_req = ~data_req;
      @(negedge CLK);
      enc_if.done = 0; enc_if.packet_done = 0;
      ack_req = 0; grtcred0_req = 0; grtcred1_req = 0;
      if (a)  m_req(0);
      if (g0) m_req(1);
      if (g1) m_req(2);
      check("hold_comma_sel", 32'(enc_if.comma_sel), t);
      check("hold_busy", busy, 1);
      check("hold_get_data", enc_if.get_data, t == 4);
    end
    if (t == 4) enc_if.packet_done = 1; else enc_if.done = 1;
    @(negedge CLK);
    enc_if.done = 0; enc_if.packet_done = 0;
    check("end_busy", busy, 0);
    check("end_comma_sel", 32'(enc_if.comma_sel), 0);
    check("end_get_data", enc_if.get_data, 0);
    check("start_seen", exp_q.size(), 0);
    exp_q.delete();
    check_status("frame");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enc_if.enc_ready = 0; enc_if.done = 0; enc_if.packet_done = 0;
    m_reset();
    @(negedge CLK);
    do_reset();

    // Single ACK with the encoder ready: start two cycles after the request
    enc_if.enc_ready = 1;
    ack_req = 1;
    exp_q.push_back(1);
    @(negedge CLK);
    ack_req = 0;
    m_req(0);
    check("lat_no_early_start", enc_if.start, 0);
    @(negedge CLK);
    m_grant(1, data_req);
    check("lat_start", enc_if.start, 1);
    check("lat_comma_sel", 32'(enc_if.comma_sel), 1);
    enc_if.enc_ready = 0;
    @(negedge CLK);
    enc_if.done = 1;
    @(negedge CLK);
    enc_if.done = 0;
    check("lat_end_busy", busy, 0);
    check("lat_end_comma_sel", 32'(enc_if.comma_sel), 0);
    check("lat_start_seen", exp_q.size(), 0);
    run_frame(0, 0);  // nothing left: must stay idle

    // Saturation and sticky overflow on the ACK counter
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      pulse_reqs(1, 0, 0);
      check("ramp_ack_full", ack_full, i >= 15);
      check("ramp_overflow", overflow_err, i == 16);
    end
    for (int i = 0; i < 15; i++) run_frame(0, 0);
    check("drain_overflow_sticky", overflow_err, 1);
    check("drain_ack_full", ack_full, 0);
    run_frame(0, 0);

    // VC round-robin with both grant counters pending
    do_reset();
    pulse_reqs(0, 1, 1);
    pulse_reqs(0, 1, 1);
    for (int i = 0; i < 5; i++) run_frame(0, 0);

    // Data forced after a run of control frames
    do_reset();
    for (int i = 0; i < 10; i++) pulse_reqs(1, 0, 0);
    data_req = 1;
    for (int i = 0; i < 13; i++) run_frame(0, 0);
    data_req = 0;

    // Request and grant in the same cycle cancel
    do_reset();
    pulse_reqs(1, 0, 0);
    run_frame(1, 0);
    run_frame(0, 0);
    run_frame(0, 0);

    // Reset asserted in the middle of a data frame
    do_reset();
    data_req = 1;
    run_frame(0, 0);           // one complete data frame first
    exp_q.push_back(m_select(data_req));
    enc_if.enc_ready = 1;
    @(negedge CLK);
    enc_if.enc_ready = 0;
    m_grant(4, data_req);
    check("mid_get_data", enc_if.get_data, 1);
    for (int i = 0; i < 16; i++) pulse_reqs(0, 1, 0);
    check_status("mid");
    #2;
    do_reset();
    data_req = 0;
    enc_if.enc_ready = 1;
    enc_if.packet_done = 1;
    @(negedge CLK);
    enc_if.packet_done = 0;
    repeat (4) @(negedge CLK);
    enc_if.enc_ready = 0;
    check("post_rst_busy", busy, 0);
    check("post_rst_get_data", enc_if.get_data, 0);
    check_status("post_rst");

    // Randomized traffic
    for (int f = 0; f < 90; f++) begin
      int nreq;
      bit co;
      if (f % 25 == 0) do_reset();
      if (f % 13 == 5) begin
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < 16; i++) pulse_reqs(k == 0, k == 1, k == 2);
      end
      nreq = $urandom_range(0, 3);
      for (int i = 0; i < nreq; i++)
        pulse_reqs($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      data_req = ($urandom_range(0, 1) == 1);
      co = ($urandom_range(0, 4) == 0) && (m_select(data_req) != 0);
      run_frame(co, 1);
    end
    data_req = 0;
    check_status("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
